// File: rtl/apb_master_arb.sv
// APB master with a two-requester round-robin front end.
// Runs one transfer at a time (SETUP, ACCESS, then back to IDLE) with an optional ACCESS-phase timeout.
module apb_master_arb #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          r0_valid,
   input  logic          r0_write,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   input  logic          r1_valid,
   input  logic          r1_write,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r0_done,
   output logic          r1_done,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          PSEL,
   output logic          PENABLE,
   output logic          PWRITE,
   output logic [AW-1:0] PADDR,
   output logic [DW-1:0] PWDATA,
   input  logic          PREADY,
   input  logic [DW-1:0] PRDATA,
   input  logic          PSLVERR,
   output logic          busy,
   output logic          grant_id
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   wait_cnt, wait_cnt_n;
   logic            last_grant, last_grant_n;
   logic            grant_id_n, busy_n;
   logic            psel_n, penable_n, pwrite_n;
   logic [AW-1:0]   paddr_n;
   logic [DW-1:0]   pwdata_n, rsp_rdata_n;
   logic            rsp_err_n, r0_done_n, r1_done_n;
   logic            elig0, elig1, sel;

   // State and registered outputs
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         busy       <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         r0_done    <= 1'b0;
         r1_done    <= 1'b0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_cnt_n;
         last_grant <= last_grant_n;
         grant_id   <= grant_id_n;
         busy       <= busy_n;
         PSEL       <= psel_n;
         PENABLE    <= penable_n;
         PWRITE     <= pwrite_n;
         PADDR      <= paddr_n;
         PWDATA     <= pwdata_n;
         rsp_rdata  <= rsp_rdata_n;
         rsp_err    <= rsp_err_n;
         r0_done    <= r0_done_n;
         r1_done    <= r1_done_n;
      end
   end

   // Arbitration: a requester being acknowledged this cycle sits out; ties go to the one not served last
   always_comb begin
      elig0 = r0_valid & ~r0_done;
      elig1 = r1_valid & ~r1_done;
      sel   = (elig0 & elig1) ? ~last_grant : elig1;
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      wait_cnt_n   = wait_cnt;
      last_grant_n = last_grant;
      grant_id_n   = grant_id;
      psel_n       = PSEL;
      penable_n    = PENABLE;
      pwrite_n     = PWRITE;
      paddr_n      = PADDR;
      pwdata_n     = PWDATA;
      rsp_rdata_n  = rsp_rdata;
      rsp_err_n    = rsp_err;
      r0_done_n    = 1'b0;
      r1_done_n    = 1'b0;

      unique case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               state_n      = SETUP;
               wait_cnt_n   = '0;
               last_grant_n = sel;
               grant_id_n   = sel;
               psel_n       = 1'b1;
               penable_n    = 1'b0;
               pwrite_n     = sel ? r1_write : r0_write;
               paddr_n      = sel ? r1_addr  : r0_addr;
               pwdata_n     = sel ? r1_wdata : r0_wdata;
            end
         end
         SETUP: begin
            state_n   = ACCESS;
            penable_n = 1'b1;
         end
         ACCESS: begin
            // Abort only once the counter already holds TIMEOUT and the completer is still not ready
            if (PREADY || ((TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT)))) begin
               state_n     = IDLE;
               psel_n      = 1'b0;
               penable_n   = 1'b0;
               pwrite_n    = 1'b0;
               paddr_n     = '0;
               pwdata_n    = '0;
               r0_done_n   = ~grant_id;
               r1_done_n   = grant_id;
               rsp_err_n   = PREADY ? PSLVERR : 1'b1;
               rsp_rdata_n = (PREADY && !PWRITE) ? PRDATA : '0;
            end else if (wait_cnt != {CW{1'b1}}) begin
               wait_cnt_n = wait_cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed self-checking bench for apb_master_arb.
module tb_apb_master_arb;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        r0_valid, r0_write, r1_valid, r1_write;
   logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
   logic        r0_done, r1_done, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        busy, grant_id;

   int total = 0;
   int passes = 0;
   int fails = 0;

   apb_master_arb #(.TIMEOUT(16), .AW(32), .DW(32)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_done(r0_done), .r1_done(r1_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " psel"},    32'(PSEL), 0);
      chk({tag, " penable"}, 32'(PENABLE), 0);
      chk({tag, " pwrite"},  32'(PWRITE), 0);
      chk({tag, " paddr"},   PADDR, 0);
      chk({tag, " pwdata"},  PWDATA, 0);
      chk({tag, " r0_done"}, 32'(r0_done), 0);
      chk({tag, " r1_done"}, 32'(r1_done), 0);
      chk({tag, " rdata"},   rsp_rdata, 0);
      chk({tag, " err"},     32'(rsp_err), 0);
      chk({tag, " busy"},    32'(busy), 0);
      chk({tag, " grant"},   32'(grant_id), 0);
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   initial begin
      PRESETn = 1'b0;
      r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
      r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
      PREADY = 0; PRDATA = 0; PSLVERR = 0;

      // Reset state
      repeat (2) @(posedge PCLK);
      #1;
      chk_all_zero("reset");
      @(negedge PCLK);
      PRESETn = 1'b1;

      // r0 write, zero wait states
      r0_valid = 1; r0_write = 1; r0_addr = 32'h14; r0_wdata = 32'hDEADBEEF; PREADY = 1;
      tick();
      chk("wr e1 psel", 32'(PSEL), 1);
      chk("wr e1 penable", 32'(PENABLE), 0);
      chk("wr e1 paddr", PADDR, 32'h14);
      chk("wr e1 pwrite", 32'(PWRITE), 1);
      chk("wr e1 pwdata", PWDATA, 32'hDEADBEEF);
      chk("wr e1 busy", 32'(busy), 1);
      chk("wr e1 grant", 32'(grant_id), 0);
      chk("wr e1 done", 32'(r0_done), 0);
      tick();
      chk("wr e2 psel", 32'(PSEL), 1);
      chk("wr e2 penable", 32'(PENABLE), 1);
      chk("wr e2 pwdata", PWDATA, 32'hDEADBEEF);
      chk("wr e2 done", 32'(r0_done), 0);
      tick();
      chk("wr e3 r0_done", 32'(r0_done), 1);
      chk("wr e3 r1_done", 32'(r1_done), 0);
      chk("wr e3 err", 32'(rsp_err), 0);
      chk("wr e3 rdata", rsp_rdata, 0);
      chk("wr e3 psel", 32'(PSEL), 0);
      chk("wr e3 paddr", PADDR, 0);
      chk("wr e3 pwdata", PWDATA, 0);
      chk("wr e3 busy", 32'(busy), 0);
      r0_valid = 0; PREADY = 0;
      tick();
      chk("wr idle done pulse", 32'(r0_done), 0);
      chk("wr idle psel", 32'(PSEL), 0);

      // r1 read with three wait states
      r1_valid = 1; r1_write = 0; r1_addr = 32'h14; r1_wdata = 32'h55; PRDATA = 32'hDEADBEEF;
      tick();
      chk("rd setup psel", 32'(PSEL), 1);
      chk("rd setup grant", 32'(grant_id), 1);
      chk("rd setup pwrite", 32'(PWRITE), 0);
      tick();
      chk("rd acc1 penable", 32'(PENABLE), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd wait psel", 32'(PSEL), 1);
         chk("rd wait penable", 32'(PENABLE), 1);
         chk("rd wait paddr", PADDR, 32'h14);
         chk("rd wait done", 32'(r1_done), 0);
      end
      PREADY = 1;
      tick();
      chk("rd r1_done", 32'(r1_done), 1);
      chk("rd r0_done", 32'(r0_done), 0);
      chk("rd rdata", rsp_rdata, 32'hDEADBEEF);
      chk("rd err", 32'(rsp_err), 0);
      r1_valid = 0; PREADY = 0; PRDATA = 32'h0;
      tick();
      chk("rd rdata hold", rsp_rdata, 32'hDEADBEEF);

      // Read with slave error
      r0_valid = 1; r0_write = 0; r0_addr = 32'h100; PREADY = 1; PSLVERR = 1; PRDATA = 32'h1234;
      tick();
      chk("err setup paddr", PADDR, 32'h100);
      chk("err setup grant", 32'(grant_id), 0);
      tick();
      tick();
      chk("err r0_done", 32'(r0_done), 1);
      chk("err rsp_err", 32'(rsp_err), 1);
      chk("err rdata", rsp_rdata, 32'h1234);
      r0_valid = 0; PREADY = 0; PSLVERR = 0; PRDATA = 32'hCAFE;
      tick();
      chk("err hold", 32'(rsp_err), 1);

      // Timeout: PREADY never rises
      r1_valid = 1; r1_write = 0; r1_addr = 32'h200;
      tick();
      tick();
      chk("to acc penable", 32'(PENABLE), 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("to wait psel", 32'(PSEL), 1);
         chk("to wait done", 32'(r1_done), 0);
      end
      tick();
      chk("to r1_done", 32'(r1_done), 1);
      chk("to rsp_err", 32'(rsp_err), 1);
      chk("to rdata", rsp_rdata, 0);
      chk("to psel", 32'(PSEL), 0);
      chk("to penable", 32'(PENABLE), 0);
      r1_valid = 0;
      tick();

      // Reset in the middle of ACCESS, then a fresh r0 write
      r0_valid = 1; r0_write = 1; r0_addr = 32'h30; r0_wdata = 32'h77;
      tick();
      tick();
      tick();
      chk("rst pre psel", 32'(PSEL), 1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk_all_zero("rst async");
      @(posedge PCLK);
      #1;
      chk("rst no done", 32'(r0_done), 0);
      chk("rst held psel", 32'(PSEL), 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      PREADY = 1;
      tick();
      chk("post rst psel", 32'(PSEL), 1);
      chk("post rst paddr", PADDR, 32'h30);
      tick();
      tick();
      chk("post rst done", 32'(r0_done), 1);
      chk("post rst err", 32'(rsp_err), 0);
      r0_valid = 0; PREADY = 0;
      tick();

      // Round robin from reset with both requesters held
      do_reset();
      r0_valid = 1; r0_write = 1; r0_addr = 32'h40; r0_wdata = 32'h11;
      r1_valid = 1; r1_write = 1; r1_addr = 32'h80; r1_wdata = 32'h22;
      PREADY = 1;
      for (int k = 0; k < 12; k++) begin
         int unsigned g;
         g = (k / 3) % 2;
         tick();
         if (k % 3 == 0) begin
            chk("rr setup psel", 32'(PSEL), 1);
            chk("rr setup grant", 32'(grant_id), g);
            chk("rr setup paddr", PADDR, (g == 0) ? 32'h40 : 32'h80);
         end else if (k % 3 == 2) begin
            chk("rr idle psel", 32'(PSEL), 0);
            chk("rr r0_done", 32'(r0_done), (g == 0) ? 1 : 0);
            chk("rr r1_done", 32'(r1_done), (g == 1) ? 1 : 0);
         end
      end
      r0_valid = 0; r1_valid = 0; PREADY = 0;
      tick();
      chk("rr end psel", 32'(PSEL), 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   // Global safety bound
   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", total);
      $fatal(1, "watchdog");
   end

endmodule
